// File: rtl/nand_seq.sv
// Bit-serial NOT/AND/OR/XOR sequencer that time-shares one external 2-input Nand gate.
// Optional abort input enabled by defining NAND_SEQ_ABORT_EN.
module nand_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef NAND_SEQ_ABORT_EN
  input  logic             abort,
`else
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             nand_a,
  output logic             nand_b,
  input  logic             nand_out
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  localparam logic [1:0] OP_NOT = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] out_q;
  logic [BW-1:0]    bit_q;
  logic [1:0]       step_q;
  logic             t0_q;
  logic             t1_q;
  logic             t2_q;

  logic             ai;
  logic             bi;
  logic [1:0]       last_step_d;
  logic             is_last_step;
  logic             nand_a_d;
  logic             nand_b_d;

  assign ai = a_q[bit_q];
  assign bi = b_q[bit_q];

  // Steps per bit minus one, i.e. the index of the step that writes the result bit.
  always_comb begin
    last_step_d = 2'd0;
    case (op_q)
      OP_NOT:  last_step_d = 2'd0;
      OP_AND:  last_step_d = 2'd1;
      OP_OR:   last_step_d = 2'd2;
      default: last_step_d = 2'd3;
    endcase
  end

  assign is_last_step = (step_q == last_step_d);

  always_comb begin
    nand_a_d = 1'b0;
    nand_b_d = 1'b0;
    if (state_q == EXEC) begin
      case (op_q)
        OP_NOT: begin
          nand_a_d = ai;
          nand_b_d = ai;
        end
        OP_AND: begin
          if (step_q == 2'd0) begin
            nand_a_d = ai;
            nand_b_d = bi;
          end else begin
            nand_a_d = t0_q;
            nand_b_d = t0_q;
          end
        end
        OP_OR: begin
          case (step_q)
            2'd0: begin
              nand_a_d = ai;
              nand_b_d = ai;
            end
            2'd1: begin
              nand_a_d = bi;
              nand_b_d = bi;
            end
            default: begin
              nand_a_d = t0_q;
              nand_b_d = t1_q;
            end
          endcase
        end
        default: begin
          case (step_q)
            2'd0: begin
              nand_a_d = ai;
              nand_b_d = bi;
            end
            2'd1: begin
              nand_a_d = ai;
              nand_b_d = t0_q;
            end
            2'd2: begin
              nand_a_d = bi;
              nand_b_d = t0_q;
            end
            default: begin
              nand_a_d = t1_q;
              nand_b_d = t2_q;
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NOT;
      out_q   <= '0;
      bit_q   <= '0;
      step_q  <= 2'd0;
      t0_q    <= 1'b0;
      t1_q    <= 1'b0;
      t2_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            out_q   <= '0;
            bit_q   <= '0;
            step_q  <= 2'd0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
`ifdef NAND_SEQ_ABORT_EN
          if (abort) begin
            out_q   <= '0;
            bit_q   <= '0;
            step_q  <= 2'd0;
            state_q <= IDLE;
          end else
`endif
          if (is_last_step) begin
            out_q[bit_q] <= nand_out;
            step_q       <= 2'd0;
            if (bit_q == LAST_BIT) begin
              bit_q   <= '0;
              state_q <= DONE;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            // Intermediate steps land in the temporary named by the step index.
            case (step_q)
              2'd0:    t0_q <= nand_out;
              2'd1:    t1_q <= nand_out;
              default: t2_q <= nand_out;
            endcase
            step_q <= step_q + 2'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = (state_q == EXEC);
  assign done   = (state_q == DONE);
  assign out    = out_q;
  assign nand_a = nand_a_d;
  assign nand_b = nand_b_d;

endmodule

// File: tb/tb_nand_seq.sv
// Directed self-checking bench for nand_seq with a behavioural Nand gate.
// Abort scenario is exercised only when NAND_SEQ_ABORT_EN is defined.
module tb_nand_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic        nand_a;
  logic        nand_b;
  logic        nand_out;
`ifdef NAND_SEQ_ABORT_EN
  logic        abort;
`endif

  int checks   = 0;
  int failures = 0;

  logic tr_a0, tr_b0, tr_a1, tr_b1;

  nand_seq #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
`ifdef NAND_SEQ_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy),
    .done     (done),
    .out      (out),
    .nand_a   (nand_a),
    .nand_b   (nand_b),
    .nand_out (nand_out)
  );

  assign nand_out = ~(nand_a & nand_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Issue one op, wait for done, and check latency, busy length, result and idle return.
  task automatic run_op(input string name, input logic [1:0] o, input logic [15:0] av,
                        input logic [15:0] bv, input logic [15:0] exp, input int s,
                        input bit repulse);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    tr_a0 = nand_a;
    tr_b0 = nand_b;
    while (!done && cyc < 200) begin
      if (busy) busy_cnt++;
      start = (repulse && cyc == 10);
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) begin
        tr_a1 = nand_a;
        tr_b1 = nand_b;
      end
    end
    start = 1'b0;
    check({name, "_done_seen"}, 32'(done), 32'd1);
    check({name, "_latency"}, 32'(cyc), 32'(16 * s + 1));
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(16 * s));
    check({name, "_out"}, 32'(out), 32'(exp));
    check({name, "_busy_in_done"}, 32'(busy), 32'd0);
    if (repulse) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    @(posedge clk); #1;
    check({name, "_idle_after"}, 32'(busy), 32'd0);
    check({name, "_out_hold"}, 32'(out), 32'(exp));
  endtask

  initial begin
    int cyc;
    int done_cnt;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
`ifdef NAND_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_nand_ab", {30'd0, nand_a, nand_b}, 32'd0);
    reset = 1'b0;

    run_op("not", 2'b00, 16'h1234, 16'h0000, 16'hEDCB, 1, 1'b0);
    run_op("and", 2'b01, 16'hFFFF, 16'h00FF, 16'h00FF, 2, 1'b0);
    check("and_trace_step0", {30'd0, tr_a0, tr_b0}, 32'd3);
    check("and_trace_step1", {30'd0, tr_a1, tr_b1}, 32'd0);
    run_op("or", 2'b10, 16'hA000, 16'h0005, 16'hA005, 3, 1'b0);
    run_op("xor", 2'b11, 16'hF0F0, 16'hFF00, 16'h0FF0, 4, 1'b0);
    run_op("xor_repulse", 2'b11, 16'hF0F0, 16'hFF00, 16'h0FF0, 4, 1'b1);

    // Reset in the middle of an XOR discards the partial result.
    @(negedge clk);
    op = 2'b11; a = 16'hF0F0; b = 16'hFF00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 21) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("xor_partial_out", 32'(out), 32'h0010);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_out", 32'(out), 32'd0);
    done_cnt = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    run_op("not_zero", 2'b00, 16'h0000, 16'h0000, 16'hFFFF, 1, 1'b0);

    // Reset and start together: reset wins and the start is dropped.
    @(negedge clk);
    op = 2'b00; a = 16'h00FF; start = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_out", 32'(out), 32'd0);
    @(posedge clk); #1;
    check("rst_start_still_idle", 32'(busy), 32'd0);

`ifdef NAND_SEQ_ABORT_EN
    @(negedge clk);
    op = 2'b10; a = 16'hA000; b = 16'h0005; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 5) begin
      @(posedge clk); #1;
      cyc++;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_out", 32'(out), 32'd0);
    done_cnt = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_op("and_after_abort", 2'b01, 16'h0F0F, 16'h00FF, 16'h000F, 2, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
